// File: rtl/hazard_ctrl_if.sv
// Hazard controller pipeline-side bundle: ID/EX hazard inputs and pipeline control outputs.
interface hazard_ctrl_if;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rt;
    logic       id_mdu_start;
    logic       id_mdu_use;
    logic       id_ex_dm_r;
    logic [4:0] id_ex_rd_addr;
    logic       ex_redirect;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mdu_busy;

    // Controller side
    modport slave (
        input  if_id_rs, if_id_rt, id_uses_rt, id_mdu_start, id_mdu_use,
               id_ex_dm_r, id_ex_rd_addr, ex_redirect,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy
    );

    // Pipeline side
    modport master (
        output if_id_rs, if_id_rt, id_uses_rt, id_mdu_start, id_mdu_use,
               id_ex_dm_r, id_ex_rd_addr, ex_redirect,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, mdu_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard / stall controller for the 5-stage MIPS core.
// Handles load-use stalls, EX redirects and MDU structural hazards.
// Optional macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 8
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic w_lu;
    logic w_sh;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;
    logic w_mdu_busy;

    // Hazard detection terms
    always_comb begin
        w_lu = bus.id_ex_dm_r
             & (bus.id_ex_rd_addr != 5'd0)
             & ((bus.id_ex_rd_addr == bus.if_id_rs)
               | (bus.id_uses_rt & (bus.id_ex_rd_addr == bus.if_id_rt)));
        w_sh = (r_state == MDU_WAIT) & bus.id_mdu_use;
    end

    // State and MDU latency counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_mdu_busy    = (r_state == MDU_WAIT);

        if (bus.ex_redirect) begin
            // squash the ID instruction; any MDU start in ID dies with it
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_lu | w_sh) begin
            // hold PC and IF/ID, bubble into ID/EX
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
        end

        case (r_state)
            RUN: begin
                if (bus.id_mdu_start && !bus.ex_redirect && !w_lu) begin
                    w_state_nxt = MDU_WAIT;
                    w_cnt_nxt   = CNT_W'(MDU_LATENCY - 1);
                end
            end
            MDU_WAIT: begin
                // a redirect does not abort the in-flight operation
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        if (reset) begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
            w_mdu_busy    = 1'b0;
        end
    end

    // Drive the pipeline controls
    always_comb begin
        bus.pc_write    = w_pc_write;
        bus.if_id_write = w_if_id_write;
        bus.if_id_flush = w_if_id_flush;
        bus.id_ex_flush = w_id_ex_flush;
        bus.mdu_busy    = w_mdu_busy;
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    // Saturating stall-cycle and redirect counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (bus.ex_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core; drives the flush and write-enable controls consumed by the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards, EX-stage control-flow redirects, and structural hazards from the multi-cycle multiply/divide unit (MDU).
- Tracks MDU occupancy with an internal FSM and a latency counter.

Parameters:
- MDU_LATENCY, 8, cycles the MDU is busy after an mult/div issues into EX; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- if_id_rs  input  5  rs field of the instruction in ID
- if_id_rt  input  5  rt field of the instruction in ID
- id_uses_rt  input  1  ID instruction reads rt as a source
- id_mdu_start  input  1  ID instruction is mult/multu/div/divu
- id_mdu_use  input  1  ID instruction is mfhi/mflo/mthi/mtlo or an MDU start
- id_ex_dm_r  input  1  EX instruction is a load
- id_ex_rd_addr  input  5  destination GPR of the EX instruction; 0 = none
- ex_redirect  input  1  branch/jump resolved taken in EX this cycle
- pc_write  output  1  1 = PC updates this cycle
- if_id_write  output  1  1 = IF/ID register loads this cycle
- if_id_flush  output  1  1 = IF/ID loads a NOP
- id_ex_flush  output  1  1 = ID/EX control fields load bubble values
- mdu_busy  output  1  MDU occupied (state MDU_WAIT)

Behaviour:
- Reset (async, active-high): state=RUN, counter=0. While reset is asserted: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, mdu_busy=0.
- FSM states: RUN, MDU_WAIT. The state and counter are registered. All control outputs are combinational functions of state and current inputs (same-cycle effect on the pipeline registers).
- Hazard terms:
  - lu = id_ex_dm_r & (id_ex_rd_addr != 0) & ((id_ex_rd_addr == if_id_rs) | (id_uses_rt & (id_ex_rd_addr == if_id_rt))).
  - sh = (state == MDU_WAIT) & id_mdu_use.
- Priority (highest first):
  1. ex_redirect=1: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. lu and sh are ignored. The ID instruction is squashed and the MDU start is suppressed.
  2. lu | sh: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0. This inserts one bubble per cycle of the stall.
  3. Otherwise: pc_write=1, if_id_write=1, both flushes 0.
- A load-use stall lasts exactly 1 cycle, because the next cycle ID/EX holds the bubble and id_ex_dm_r=0.
- RUN -> MDU_WAIT when id_mdu_start=1 and the priority 3 case applies (no redirect, no lu). On this transition counter loads MDU_LATENCY-1.
- MDU_WAIT: mdu_busy=1. The counter decrements every cycle. When counter==0 on a clock edge, the FSM returns to RUN.
  - The MDU is busy for exactly MDU_LATENCY cycles after issue.
  - An id_mdu_start cannot be accepted in MDU_WAIT, since it is covered by sh. It is accepted in the first RUN cycle.
- ex_redirect during MDU_WAIT flushes the front end but does not abort the counter; the issued op completes.
- Counter width: 8 bits; no wrap (it never decrements below 0).
- Reset mid-operation: MDU_WAIT is abandoned immediately; outputs return to reset values asynchronously.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with ex_redirect=1.
  - Both are cleared by reset, saturate at 32'hFFFFFFFF, and do not wrap.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Load-use on rs: id_ex_dm_r=1, id_ex_rd_addr=5, if_id_rs=5 -> in that cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (id_ex_dm_r=0) all outputs return to normal. id_ex_rd_addr=0 with if_id_rs=0 -> no stall.
- rt gating: id_ex_rd_addr=7, if_id_rt=7, id_uses_rt=0 -> no stall; id_uses_rt=1 -> stall.
- Redirect priority: ex_redirect=1 together with the load-use condition -> if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1; id_mdu_start=1 in the same cycle -> state stays RUN, mdu_busy stays 0.
- MDU occupancy (MDU_LATENCY=8): pulse id_mdu_start in RUN -> mdu_busy high for exactly 8 cycles. An id_mdu_use held high during that window -> pc_write=0 for all 8 cycles, with the first unstalled cycle coinciding with mdu_busy=0.
- Reset mid-MDU: assert reset 3 cycles after issue, between clock edges -> mdu_busy=0 and state RUN immediately. After reset deasserts, pc_write=1 with no residual stall.
- HAZARD_PERF_EN: a 1-cycle load-use stall, 8 MDU stall cycles and 2 redirects -> stall_cnt=9, flush_cnt=2. Preloading near saturation in simulation -> the counters hold at 32'hFFFFFFFF.
